alu_seq: RTL

- Parametrised, clocked successor to the single-cycle datapath ALU.
- Registers every result and adds HI/LO, a multi-cycle unsigned multiply/divide engine, signed overflow and a Start/Busy/Done handshake.
- Sits in the execute stage. The controller issues one operation per Start pulse and stalls the pipeline while Busy is high.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Clocked execute-stage ALU: registered single-cycle ops plus a multi-cycle
// unsigned multiply/divide engine feeding HI/LO, with Start/Busy/Done handshake.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic             UseImm,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Immediate,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_reg, state_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0]   opd_reg, opd_next;
  logic [WIDTH-1:0]   wh_reg, wh_next;
  logic [WIDTH-1:0]   wl_reg, wl_next;
  logic [WIDTH-1:0]   res_reg, res_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               zero_reg, zero_next;
  logic               ovf_reg, ovf_next;
  logic               done_reg, done_next;

  logic [WIDTH-1:0]   op2, sum, diff, alu_res;
  logic [SHAMT_W-1:0] sh;
  logic               alu_ovf;

  assign op2  = UseImm ? Immediate : B;
  assign sh   = A[SHAMT_W-1:0];
  assign sum  = A + op2;
  assign diff = A - op2;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUControl)
      4'b0000: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: alu_res = A & op2;
      4'b0011: alu_res = A | op2;
      4'b0100: alu_res = A ^ op2;
      4'b0101: alu_res = {op2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0110: alu_res = ~(A | op2);
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(op2))};
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, (A < op2)};
      4'b1001: alu_res = op2 << sh;
      4'b1010: alu_res = op2 >> sh;
      4'b1011: alu_res = $signed(op2) >>> sh;
      4'b1110: alu_res = hi_reg;
      4'b1111: alu_res = lo_reg;
      default: alu_res = '0;
    endcase
  end

  // Multiply step: {wh,wl} holds partial product and remaining multiplier bits.
  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign madd   = {1'b0, wh_reg} + {1'b0, (wl_reg[0] ? opd_reg : {WIDTH{1'b0}})};
  assign mul_hi = madd[WIDTH:1];
  assign mul_lo = {madd[0], wl_reg[WIDTH-1:1]};

  // Restoring divide step: wh is the partial remainder, wl shifts dividend out and quotient in.
  logic [WIDTH:0]   dshift;
  logic [WIDTH-1:0] dsub, div_rem, div_quo;
  logic             dge;
  assign dshift  = {wh_reg, wl_reg[WIDTH-1]};
  assign dge     = dshift >= {1'b0, opd_reg};
  assign dsub    = dshift[WIDTH-1:0] - opd_reg;
  assign div_rem = dge ? dsub : dshift[WIDTH-1:0];
  assign div_quo = {wl_reg[WIDTH-2:0], dge};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    opd_next   = opd_reg;
    wh_next    = wh_reg;
    wl_next    = wl_reg;
    res_next   = res_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          if (ALUControl == 4'b1100 || ALUControl == 4'b1101) begin
            state_next = (ALUControl == 4'b1100) ? MUL : DIV;
            opd_next   = op2;
            wh_next    = '0;
            wl_next    = A;
            cnt_next   = '0;
          end else begin
            res_next  = alu_res;
            zero_next = (alu_res == '0);
            ovf_next  = alu_ovf;
            done_next = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        wh_next  = (state_reg == MUL) ? mul_hi : div_rem;
        wl_next  = (state_reg == MUL) ? mul_lo : div_quo;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == SHAMT_W'(WIDTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          hi_next    = wh_next;
          lo_next    = wl_next;
          res_next   = wl_next;
          zero_next  = (wl_next == '0);
          ovf_next   = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      opd_reg   <= '0;
      wh_reg    <= '0;
      wl_reg    <= '0;
      res_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      zero_reg  <= 1'b1;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      opd_reg   <= opd_next;
      wh_reg    <= wh_next;
      wl_reg    <= wl_next;
      res_reg   <= res_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
    end
  end

  assign ALUResult = res_reg;
  assign Zero      = zero_reg;
  assign Overflow  = ovf_reg;
  assign Busy      = (state_reg != IDLE);
  assign Done      = done_reg;
  assign HI        = hi_reg;
  assign LO        = lo_reg;

endmodule
